// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package fetch_unit_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    // Word-aligned check on the low address bits
    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO of {pc, instr} with flush; head is shown combinationally.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: caller guarantees no push when full; head holds while not popped, last head held when empty.
module fetch_unit_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output logic                   head_vld,
    output logic [WIDTH-1:0]       head_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] last_dat;

    // Pointer and occupancy tracking; flush empties without touching storage
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Entry storage, written only on a real push
    always_ff @(posedge clk) begin
        if (rst && !flush && push) mem[wr_ptr] <= push_dat;
    end

    // Remember the last visible head so outputs hold while the FIFO is empty
    always_ff @(posedge clk) begin
        if (!rst) last_dat <= '0;
        else      last_dat <= head_dat;
    end

    // Head presentation
    always_comb begin
        head_vld = (cnt != '0);
        head_dat = head_vld ? mem[rd_ptr] : last_dat;
        count    = cnt;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word reads (req/ack, rvalid), buffers {pc, instr} for decode.
// Latency: req at N with same-cycle ack, rvalid N+1, instr_valid N+2; one instruction per two cycles.
// Backpressure: a FIFO slot is reserved before each request, so fetching stalls in IDLE when decode stalls.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN       = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEF,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            j_signal,
    input  logic [XLEN-1:0] jump,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc_out,
    output logic            fetch_fault
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] addr_q;
    logic            drop;
    logic            fault;
    logic            misalign;
    logic            push;
    logic            pop;
    logic            flush;
    logic [CW-1:0]   count;
    logic [CW-1:0]   cnt_after;
    logic            room;
    logic [2*XLEN-1:0] head_dat;

    // Redirect beats push and pop; a response landing in a redirect cycle is discarded
    always_comb begin
        misalign  = j_signal && !is_aligned(jump[1:0]);
        flush     = j_signal;
        push      = (state == ST_WAIT) && imem_rvalid && !drop && !j_signal;
        pop       = instr_valid && instr_ready && !j_signal;
        cnt_after = flush ? '0 : count + CW'(push) - CW'(pop);
        room      = cnt_after < CW'(FIFO_DEPTH);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= nxt;
    end

    // Next state: a request is only issued when a FIFO slot is free after this edge
    always_comb begin
        nxt = state;
        if (misalign) begin
            nxt = ST_FAULT;
        end else begin
            case (state)
                ST_IDLE:  if (room)        nxt = ST_REQ;
                ST_REQ:   if (imem_ack)    nxt = ST_WAIT;
                ST_WAIT:  if (imem_rvalid) nxt = room ? ST_REQ : ST_IDLE;
                ST_FAULT: if (j_signal)    nxt = ST_REQ;
                default:                   nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        imem_req    = (state == ST_REQ);
        imem_addr   = addr_q;
        fetch_fault = fault;
    end

    // PC, request address, drop flag and sticky fault
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            addr_q   <= RESET_PC;
            drop     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            if (misalign) fault <= 1'b1;

            // A dropped request must not advance the PC: fetch_pc already holds the target
            if (j_signal) begin
                if (!misalign) fetch_pc <= jump;
            end else if (state == ST_REQ && imem_ack && !drop) begin
                fetch_pc <= addr_q + XLEN'(4);
            end

            // Address is captured only on entry to REQ so it stays put until ack
            if (nxt == ST_REQ && state != ST_REQ) addr_q <= j_signal ? jump : fetch_pc;

            // FAULT ignores responses itself, so drop is cleared to avoid eating the next real one
            if (misalign || state == ST_FAULT)                       drop <= 1'b0;
            else if (state == ST_WAIT && imem_rvalid)                 drop <= 1'b0;
            else if (j_signal && (state == ST_REQ || state == ST_WAIT)) drop <= 1'b1;
        end
    end

    fetch_unit_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (push),
        .push_dat ({addr_q, imem_rdata}),
        .pop      (pop),
        .count    (count),
        .head_vld (instr_valid),
        .head_dat (head_dat)
    );

    // Split the head entry for decode
    always_comb begin
        pc_out = head_dat[2*XLEN-1:XLEN];
        instr  = head_dat[XLEN-1:0];
    end

endmodule
